// File: rtl/pulse_led.sv
// Queued LED flasher: each pulse_in request produces one ON_CYCLES-long flash followed
// by a mandatory OFF_CYCLES gap; surplus requests wait in a saturating counter.
module pulse_led #(
  parameter int ON_CYCLES   = 5_000_000,
  parameter int OFF_CYCLES  = 5_000_000,
  parameter int MAX_PENDING = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             pulse_in,
  output logic                             led_n,
  output logic                             busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int PW      = $clog2(MAX_PENDING + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [PW-1:0] P_MAX    = PW'(MAX_PENDING);
  localparam logic [PW-1:0] P_ZERO   = PW'(0);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic            last_off_s;
  logic            accept_s;
  logic            consume_s;
  logic            drop_s;
  logic [PW-1:0]   pending_next_s;

  // Queue bookkeeping; a request in the final OFF cycle with an empty queue starts directly
  always_comb begin
    last_off_s     = 1'b0;
    accept_s       = 1'b0;
    consume_s      = 1'b0;
    drop_s         = 1'b0;
    pending_next_s = pending;
    last_off_s = (state_r == OFF) && (timer_r == T_ONE);
    consume_s  = last_off_s && (pending != P_ZERO);
    if (state_r == ON) begin
      accept_s = pulse_in;
    end else if (state_r == OFF) begin
      accept_s = pulse_in && !(last_off_s && (pending == P_ZERO));
    end else begin
      accept_s = 1'b0;
    end
    drop_s = accept_s && !consume_s && (pending == P_MAX);
    if (accept_s && !consume_s && !drop_s) begin
      pending_next_s = pending + P_ONE;
    end else if (consume_s && !accept_s) begin
      pending_next_s = pending - P_ONE;
    end else begin
      pending_next_s = pending;
    end
  end

  // Flash sequencer with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      led_n    <= 1'b1;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next_s;
      overflow <= drop_s;
      case (state_r)
        IDLE: begin
          if (pulse_in) begin
            state_r <= ON;
            timer_r <= ON_LOAD;
            led_n   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            led_n   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        ON: begin
          if (timer_r == T_ONE) begin
            state_r <= OFF;
            timer_r <= OFF_LOAD;
            led_n   <= 1'b1;
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        OFF: begin
          if (last_off_s) begin
            if ((pending != P_ZERO) || pulse_in) begin
              state_r <= ON;
              timer_r <= ON_LOAD;
              led_n   <= 1'b0;
            end else begin
              state_r <= IDLE;
              timer_r <= '0;
              busy    <= 1'b0;
            end
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= '0;
          led_n   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_led.sv
// Directed bench for pulse_led with ON=4, OFF=3, MAX_PENDING=2: per-scenario pulse
// masks plus a table of hand-computed per-cycle expectations.
module tb_pulse_led;

  logic       clk;
  logic       reset_n;
  logic       pulse_in;
  logic       led_n;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  pulse_led #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pulse_in (pulse_in),
    .led_n    (led_n),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sid;
    int         cyc;
    logic       led_n;
    logic       busy;
    logic [1:0] pend;
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] pmask   [7];
  int          rst_at  [7];
  int          ovf_at  [7];
  int          flashes [7];

  function automatic void add(input int s, input int c, input logic l, input logic b, input logic [1:0] p);
    vec_t v;
    v.sid = s; v.cyc = c; v.led_n = l; v.busy = b; v.pend = p;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int sid, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s scen=%0d cyc=%0d got=%0d want=%0d", name, sid, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    pulse_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_scen(input int s);
    logic prev_led;
    int   nflash;
    prev_led = 1'b1;
    nflash   = 0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      pulse_in = pmask[s][k];
      reset_n  = (rst_at[s] >= 0 && (k == rst_at[s] || k == rst_at[s] + 1)) ? 1'b0 : 1'b1;
      #1;
      foreach (tbl[i]) begin
        if (tbl[i].sid == s && tbl[i].cyc == k) begin
          check("led_n",   s, k, int'(led_n),   int'(tbl[i].led_n));
          check("busy",    s, k, int'(busy),    int'(tbl[i].busy));
          check("pending", s, k, int'(pending), int'(tbl[i].pend));
        end
      end
      check("overflow", s, k, int'(overflow), (k == ovf_at[s]) ? 1 : 0);
      if (prev_led && !led_n) nflash++;
      prev_led = led_n;
    end
    check("flash_count", s, 36, nflash, flashes[s]);
  endtask

  initial begin
    reset_n  = 1'b0;
    pulse_in = 1'b0;
    // Scenario stimulus: bit k of pmask is pulse_in sampled at edge k
    pmask[0] = 36'h0; pmask[0][10] = 1'b1;
    pmask[1] = 36'h0; pmask[1][10] = 1'b1; pmask[1][12] = 1'b1; pmask[1][13] = 1'b1;
    pmask[2] = pmask[1]; pmask[2][14] = 1'b1;
    pmask[3] = 36'h0; pmask[3][10] = 1'b1; pmask[3][17] = 1'b1;
    pmask[4] = 36'h0; pmask[4][10] = 1'b1; pmask[4][12] = 1'b1;
    pmask[5] = pmask[1]; pmask[5][17] = 1'b1;
    pmask[6] = 36'h0; pmask[6][0] = 1'b1; pmask[6][1] = 1'b1; pmask[6][2] = 1'b1;
    rst_at  = '{-1, -1, -1, -1, 13, -1, -1};
    ovf_at  = '{-1, -1, 15, -1, -1, -1, -1};
    flashes = '{1, 3, 3, 2, 1, 4, 3};

    add(0, 10, 1'b1, 1'b0, 2'd0); add(0, 11, 1'b0, 1'b1, 2'd0); add(0, 14, 1'b0, 1'b1, 2'd0);
    add(0, 15, 1'b1, 1'b1, 2'd0); add(0, 17, 1'b1, 1'b1, 2'd0); add(0, 18, 1'b1, 1'b0, 2'd0);

    add(1, 12, 1'b0, 1'b1, 2'd0); add(1, 13, 1'b0, 1'b1, 2'd1); add(1, 14, 1'b0, 1'b1, 2'd2);
    add(1, 15, 1'b1, 1'b1, 2'd2); add(1, 17, 1'b1, 1'b1, 2'd2); add(1, 18, 1'b0, 1'b1, 2'd1);
    add(1, 21, 1'b0, 1'b1, 2'd1); add(1, 22, 1'b1, 1'b1, 2'd1); add(1, 24, 1'b1, 1'b1, 2'd1);
    add(1, 25, 1'b0, 1'b1, 2'd0); add(1, 28, 1'b0, 1'b1, 2'd0); add(1, 29, 1'b1, 1'b1, 2'd0);
    add(1, 31, 1'b1, 1'b1, 2'd0); add(1, 32, 1'b1, 1'b0, 2'd0);

    add(2, 14, 1'b0, 1'b1, 2'd2); add(2, 15, 1'b1, 1'b1, 2'd2); add(2, 18, 1'b0, 1'b1, 2'd1);
    add(2, 25, 1'b0, 1'b1, 2'd0); add(2, 32, 1'b1, 1'b0, 2'd0);

    add(3, 17, 1'b1, 1'b1, 2'd0); add(3, 18, 1'b0, 1'b1, 2'd0); add(3, 21, 1'b0, 1'b1, 2'd0);
    add(3, 22, 1'b1, 1'b1, 2'd0); add(3, 24, 1'b1, 1'b1, 2'd0); add(3, 25, 1'b1, 1'b0, 2'd0);

    add(4, 12, 1'b0, 1'b1, 2'd0); add(4, 13, 1'b1, 1'b0, 2'd0); add(4, 14, 1'b1, 1'b0, 2'd0);
    add(4, 15, 1'b1, 1'b0, 2'd0); add(4, 20, 1'b1, 1'b0, 2'd0);

    add(5, 17, 1'b1, 1'b1, 2'd2); add(5, 18, 1'b0, 1'b1, 2'd2); add(5, 21, 1'b0, 1'b1, 2'd2);
    add(5, 22, 1'b1, 1'b1, 2'd2); add(5, 25, 1'b0, 1'b1, 2'd1); add(5, 32, 1'b0, 1'b1, 2'd0);

    add(6, 1, 1'b0, 1'b1, 2'd0); add(6, 2, 1'b0, 1'b1, 2'd1); add(6, 3, 1'b0, 1'b1, 2'd2);
    add(6, 5, 1'b1, 1'b1, 2'd2); add(6, 8, 1'b0, 1'b1, 2'd1); add(6, 15, 1'b0, 1'b1, 2'd0);
    add(6, 22, 1'b1, 1'b0, 2'd0);

    // Reset state, checked mid-reset with the clock running
    repeat (2) @(negedge clk);
    #1;
    check("rst_led_n",    -1, 0, int'(led_n),    1);
    check("rst_busy",     -1, 0, int'(busy),     0);
    check("rst_pending",  -1, 0, int'(pending),  0);
    check("rst_overflow", -1, 0, int'(overflow), 0);

    for (int s = 0; s < 7; s++) run_scen(s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
